// File: rtl/kernel_run_ctrl.sv
// Kernel run controller: start edge detect, single launch pulse, masked done collection,
// ap_ctrl_hs / ap_ctrl_chain handshake and run cycle counter. Optional watchdog: KERNEL_RUN_CTRL_TIMEOUT_EN.
module kernel_run_ctrl #(
  parameter int unsigned C_NUM_CHANNELS = 3,
  parameter int unsigned C_CLS_WIDTH    = 32,
  parameter int unsigned C_CNT_WIDTH    = 48
) (
  input  logic                                       data_clk,
  input  logic                                       data_rst_n,
  input  logic                                       ap_start,
  input  logic                                       ap_continue,
  output logic                                       ap_idle,
  output logic                                       ap_ready,
  output logic                                       ap_done,
  input  logic                                       ctrl_chain_i,
  input  logic [C_NUM_CHANNELS-1:0]                  chan_mask_i,
  input  logic [C_NUM_CHANNELS*C_CLS_WIDTH-1:0]      cfg_cls_i,
  output logic [C_NUM_CHANNELS*(C_CLS_WIDTH+6)-1:0]  cfg_bytes_o,
  output logic                                       ctrl_start_o,
  input  logic [C_NUM_CHANNELS-1:0]                  chan_done_i,
  input  logic [C_CNT_WIDTH-1:0]                     timeout_cycles_i,
  output logic [C_CNT_WIDTH-1:0]                     run_cycles_o,
  output logic                                       timed_out_o
);

  localparam int unsigned N  = C_NUM_CHANNELS;
  localparam int unsigned BW = C_CLS_WIDTH + 6;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               start_r_q, start_r_d;
  logic               chain_q, chain_d;
  logic [N-1:0]       mask_q, mask_d;
  logic [N-1:0]       sticky_q, sticky_d;
  logic [N*BW-1:0]    bytes_q, bytes_d;
  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic               timed_out_q, timed_out_d;
  logic               ap_idle_q, ap_idle_d;
  logic               ap_ready_q, ap_ready_d;
  logic               ap_done_q, ap_done_d;
  logic               launch_q, launch_d;

  logic                   start_edge_c;
  logic                   all_done_c;
  logic [C_CNT_WIDTH-1:0] cnt_inc_c;
  logic                   timeout_hit_c;

  assign start_edge_c = ap_start & ~start_r_q;
  // A done arriving this cycle completes its channel immediately.
  assign all_done_c   = &(sticky_q | chan_done_i | ~mask_q);
  assign cnt_inc_c    = (cnt_q == {C_CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + C_CNT_WIDTH'(1);

`ifdef KERNEL_RUN_CTRL_TIMEOUT_EN
  // Limit compares against the count including the current cycle, so a timed-out run reports exactly the limit.
  assign timeout_hit_c = (timeout_cycles_i != '0) && (cnt_inc_c >= timeout_cycles_i);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles_i;
  assign timeout_hit_c  = 1'b0;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    start_r_d   = ap_start;
    chain_d     = chain_q;
    mask_d      = mask_q;
    sticky_d    = sticky_q;
    bytes_d     = bytes_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge_c) begin
          chain_d     = ctrl_chain_i;
          mask_d      = chan_mask_i;
          sticky_d    = '0;
          cnt_d       = '0;
          timed_out_d = 1'b0;
          for (int unsigned i = 0; i < N; i++) begin
            bytes_d[i*BW +: BW] = {cfg_cls_i[i*C_CLS_WIDTH +: C_CLS_WIDTH], 6'b0};
          end
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = cnt_inc_c;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d    = cnt_inc_c;
        sticky_d = sticky_q | chan_done_i;
        if (all_done_c) begin
          state_d = S_DONE;
        end else if (timeout_hit_c) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end
      end
      S_DONE: begin
        if (!chain_q || ap_continue) state_d = S_IDLE;
        else                         state_d = S_HOLD;
      end
      S_HOLD: begin
        if (ap_continue) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ap_idle_d  = (state_d == S_IDLE);
    ap_ready_d = (state_d == S_LAUNCH);
    launch_d   = (state_d == S_LAUNCH);
    ap_done_d  = (state_d == S_DONE) || (state_d == S_HOLD);
  end

  always_ff @(posedge data_clk) begin
    if (!data_rst_n) begin
      state_q     <= S_IDLE;
      start_r_q   <= 1'b0;
      chain_q     <= 1'b0;
      mask_q      <= '0;
      sticky_q    <= '0;
      bytes_q     <= '0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      ap_idle_q   <= 1'b1;
      ap_ready_q  <= 1'b0;
      ap_done_q   <= 1'b0;
      launch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_r_q   <= start_r_d;
      chain_q     <= chain_d;
      mask_q      <= mask_d;
      sticky_q    <= sticky_d;
      bytes_q     <= bytes_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
      ap_idle_q   <= ap_idle_d;
      ap_ready_q  <= ap_ready_d;
      ap_done_q   <= ap_done_d;
      launch_q    <= launch_d;
    end
  end

  assign ap_idle      = ap_idle_q;
  assign ap_ready     = ap_ready_q;
  assign ap_done      = ap_done_q;
  assign ctrl_start_o = launch_q;
  assign cfg_bytes_o  = bytes_q;
  assign run_cycles_o = cnt_q;
  assign timed_out_o  = timed_out_q;

endmodule

// File: tb/tb_kernel_run_ctrl.sv
// Directed bench for kernel_run_ctrl (default parameters); watchdog steps only when KERNEL_RUN_CTRL_TIMEOUT_EN is defined.
module tb_kernel_run_ctrl;

  localparam int unsigned N  = 3;
  localparam int unsigned CW = 32;
  localparam int unsigned BW = CW + 6;
  localparam int unsigned TW = 48;

  logic            data_clk;
  logic            data_rst_n;
  logic            ap_start;
  logic            ap_continue;
  logic            ap_idle;
  logic            ap_ready;
  logic            ap_done;
  logic            ctrl_chain_i;
  logic [N-1:0]    chan_mask_i;
  logic [N*CW-1:0] cfg_cls_i;
  logic [N*BW-1:0] cfg_bytes_o;
  logic            ctrl_start_o;
  logic [N-1:0]    chan_done_i;
  logic [TW-1:0]   timeout_cycles_i;
  logic [TW-1:0]   run_cycles_o;
  logic            timed_out_o;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_ready = 0;
  int n_both  = 0;
  int ready_snap;
  logic [N*BW-1:0] exp_bytes;

  kernel_run_ctrl dut (
    .data_clk         (data_clk),
    .data_rst_n       (data_rst_n),
    .ap_start         (ap_start),
    .ap_continue      (ap_continue),
    .ap_idle          (ap_idle),
    .ap_ready         (ap_ready),
    .ap_done          (ap_done),
    .ctrl_chain_i     (ctrl_chain_i),
    .chan_mask_i      (chan_mask_i),
    .cfg_cls_i        (cfg_cls_i),
    .cfg_bytes_o      (cfg_bytes_o),
    .ctrl_start_o     (ctrl_start_o),
    .chan_done_i      (chan_done_i),
    .timeout_cycles_i (timeout_cycles_i),
    .run_cycles_o     (run_cycles_o),
    .timed_out_o      (timed_out_o)
  );

  initial data_clk = 1'b0;
  always #5 data_clk = ~data_clk;

  always @(negedge data_clk) begin
    if (ctrl_start_o) n_start++;
    if (ap_ready) n_ready++;
    if (ap_done && ap_idle) n_both++;
  end

  task automatic tick();
    @(posedge data_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    data_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0; ctrl_chain_i = 1'b0;
    chan_mask_i = '0; cfg_cls_i = '0; chan_done_i = '0; timeout_cycles_i = '0;
    tick(); tick();
    chk("rst_idle", ap_idle, 1); chk("rst_ready", ap_ready, 0); chk("rst_done", ap_done, 0);
    chk("rst_start", ctrl_start_o, 0); chk("rst_bytes", cfg_bytes_o, 0);
    chk("rst_cycles", run_cycles_o, 0); chk("rst_tout", timed_out_o, 0);
    data_rst_n = 1'b1;
    tick();

    // hs run: cls ch2=2 ch1=10 ch0=4, dones at RUN cycles 5, 9, 20 (0-based)
    chan_mask_i = 3'b111;
    cfg_cls_i = {32'd2, 32'd10, 32'd4};
    ap_start = 1'b1;
    tick();
    exp_bytes = {38'd128, 38'd640, 38'd256};
    chk("hs_launch_start", ctrl_start_o, 1); chk("hs_launch_ready", ap_ready, 1);
    chk("hs_launch_idle", ap_idle, 0); chk("hs_bytes", cfg_bytes_o, exp_bytes);
    ap_start = 1'b0;
    tick();
    chk("hs_start_one_cycle", ctrl_start_o, 0);
    for (int r = 0; r <= 20; r++) begin
      chan_done_i = (r == 5) ? 3'b001 : (r == 9) ? 3'b010 : (r == 20) ? 3'b100 : 3'b000;
      chk("hs_no_early_done", ap_done, 0);
      tick();
    end
    chan_done_i = '0;
    chk("hs_done", ap_done, 1); chk("hs_done_idle", ap_idle, 0);
    chk("hs_cycles", run_cycles_o, 22);
    tick();
    chk("hs_done_one_cycle", ap_done, 0); chk("hs_idle_after", ap_idle, 1);
    chk("hs_cycles_hold", run_cycles_o, 22); chk("hs_start_pulses", n_start, 1);

    // chain hold: continue asserted 7 cycles after DONE
    ctrl_chain_i = 1'b1;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0; ctrl_chain_i = 1'b0;
    tick();
    chan_done_i = 3'b111;
    tick();
    chan_done_i = '0;
    chk("ch_cycles", run_cycles_o, 2);
    for (int c = 0; c < 7; c++) begin
      chk("ch_done_held", ap_done, 1); chk("ch_not_idle", ap_idle, 0);
      tick();
    end
    ap_continue = 1'b1;
    chk("ch_done_last", ap_done, 1);
    tick();
    ap_continue = 1'b0;
    chk("ch_done_drop", ap_done, 0); chk("ch_idle_rise", ap_idle, 1);

    // done pulses during LAUNCH are ignored
    chan_mask_i = 3'b111;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    chan_done_i = 3'b111;
    tick();
    chan_done_i = '0;
    tick(); tick(); tick();
    chk("launch_done_ignored", ap_done, 0);
    chan_done_i = 3'b111;
    tick();
    chan_done_i = '0;
    chk("launch_done_later", ap_done, 1);
    tick();

    // mask 010: strays on 0/2 during LAUNCH, channel 1 at RUN cycle 3
    chan_mask_i = 3'b010;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    chan_done_i = 3'b101;
    tick();
    chan_done_i = '0;
    tick(); tick();
    chk("mask_wait", ap_done, 0);
    tick();
    chan_done_i = 3'b010;
    chk("mask_wait3", ap_done, 0);
    tick();
    chan_done_i = '0;
    chk("mask_done", ap_done, 1); chk("mask_cycles", run_cycles_o, 5);
    tick();

    // all-zero mask: done exactly 3 cycles after the sampled edge
    chan_mask_i = 3'b000;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    chk("zero_launch", ap_ready, 1);
    tick();
    chk("zero_run", ap_done, 0);
    tick();
    chk("zero_done", ap_done, 1); chk("zero_cycles", run_cycles_o, 2);
    tick();

    // restart rejection
    chan_mask_i = 3'b111;
    cfg_cls_i = {32'd1, 32'd2, 32'd3};
    ap_start = 1'b1;
    tick();
    exp_bytes = {38'd64, 38'd128, 38'd192};
    chk("rs_bytes", cfg_bytes_o, exp_bytes);
    ready_snap = n_ready + 1;
    ap_start = 1'b0;
    tick();
    cfg_cls_i = {32'd7, 32'd7, 32'd7};
    ap_start = 1'b1; tick();
    ap_start = 1'b0; tick();
    ap_start = 1'b1; tick();
    chk("rs_no_ready", n_ready, ready_snap); chk("rs_bytes_stable", cfg_bytes_o, exp_bytes);
    chan_done_i = 3'b111;
    tick();
    chan_done_i = '0;
    chk("rs_done", ap_done, 1);
    tick(); tick(); tick(); tick();
    chk("rs_held_idle", ap_idle, 1); chk("rs_held_no_ready", n_ready, ready_snap);
    ap_start = 1'b0; tick();
    ap_start = 1'b1; tick();
    exp_bytes = {38'd448, 38'd448, 38'd448};
    chk("rs_relaunch", ap_ready, 1); chk("rs_new_bytes", cfg_bytes_o, exp_bytes);
    ap_start = 1'b0;
    tick();
    chan_done_i = 3'b111;
    tick();
    chan_done_i = '0;
    tick();
    chk("rs_back_idle", ap_idle, 1);

    // reset mid-run
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick(); tick(); tick();
    data_rst_n = 1'b0;
    tick();
    data_rst_n = 1'b1;
    chk("mr_idle", ap_idle, 1); chk("mr_ready", ap_ready, 0); chk("mr_done", ap_done, 0);
    chk("mr_start", ctrl_start_o, 0); chk("mr_bytes", cfg_bytes_o, 0);
    chk("mr_cycles", run_cycles_o, 0); chk("mr_tout", timed_out_o, 0);
    chan_done_i = 3'b111;
    tick();
    chan_done_i = '0;
    tick(); tick();
    chk("mr_late_done", ap_done, 0); chk("mr_still_idle", ap_idle, 1);

`ifdef KERNEL_RUN_CTRL_TIMEOUT_EN
    begin
      int waited;
      timeout_cycles_i = 48'd50;
      chan_mask_i = 3'b111;
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      waited = 0;
      while (!ap_done && waited < 200) begin
        tick();
        waited++;
      end
      chk("wd_done", ap_done, 1); chk("wd_waited", waited, 50);
      chk("wd_tout", timed_out_o, 1); chk("wd_cycles", run_cycles_o, 50);
      tick();
      chk("wd_tout_hold", timed_out_o, 1);
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      chk("wd_tout_clear", timed_out_o, 0);
      tick();
      for (int r = 0; r < 48; r++) tick();
      chk("wd_pre", ap_done, 0);
      chan_done_i = 3'b111;
      tick();
      chan_done_i = '0;
      chk("wd_tie_done", ap_done, 1); chk("wd_tie_tout", timed_out_o, 0);
      chk("wd_tie_cycles", run_cycles_o, 50);
      timeout_cycles_i = '0;
      tick();
    end
`endif

    chk("never_done_and_idle", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_run_ctrl.md
# kernel_run_ctrl

Parametrised kernel run controller for the erbium SDx kernels, generalising the inline ap_start/ap_idle/ap_done logic of the kernel top level. It sits between the SDx control signals and the datapath (input channel, engine wrapper, write master) in the `data_clk` domain. It latches per-channel transfer sizes and converts them from cache lines to bytes. It issues a single launch pulse, collects done pulses from N datapath channels (maskable), and supports both ap_ctrl_hs and ap_ctrl_chain handshakes. It also reports a per-run cycle count.

## Interface
Parameters:
- `C_NUM_CHANNELS`, 3: number of datapath channels whose completion is collected; range 1..16.
- `C_CLS_WIDTH`, 32: width of each cache-line count.
- `C_CNT_WIDTH`, 48: width of the run cycle counter.

Ports:
- `data_clk`  in  1: single clock for all logic.
- `data_rst_n`  in  1: reset, synchronous, active-low.
- `ap_start`  in  1: SDx start level; launch on rising edge.
- `ap_continue`  in  1: SDx continue; used only in chain mode.
- `ap_idle`  out  1: kernel idle.
- `ap_ready`  out  1: one-cycle pulse when a start is accepted.
- `ap_done`  out  1: run complete.
- `ctrl_chain_i`  in  1: 1 selects ap_ctrl_chain; sampled at start accept.
- `chan_mask_i`  in  C_NUM_CHANNELS: 1 = channel participates; sampled at start accept.
- `cfg_cls_i`  in  C_NUM_CHANNELS*C_CLS_WIDTH: per-channel size in 64-byte lines; channel i occupies bits [i*C_CLS_WIDTH +: C_CLS_WIDTH].
- `cfg_bytes_o`  out  C_NUM_CHANNELS*(C_CLS_WIDTH+6): latched sizes in bytes.
- `ctrl_start_o`  out  1: one-cycle launch pulse to the datapath.
- `chan_done_i`  in  C_NUM_CHANNELS: per-channel done pulses or levels.
- `timeout_cycles_i`  in  C_CNT_WIDTH: watchdog limit; 0 = disabled.
- `run_cycles_o`  out  C_CNT_WIDTH: cycles of the current or last run.
- `timed_out_o`  out  1: the last run ended by watchdog.

## Operation
The controller is a five-state FSM: IDLE, LAUNCH, RUN, DONE, HOLD.

**Start detection**
- `start_r` registers `ap_start`.
- An edge is `ap_start & ~start_r`.
- An edge seen outside IDLE is dropped; there is no queueing.

**IDLE**
- On an edge:
  - latch `ctrl_chain_i` and `chan_mask_i`;
  - latch `cfg_bytes_o[i] = {cfg_cls_i[i], 6'b0}` (zero-extended; no overflow is possible);
  - clear the sticky done bits, `run_cycles_o` and `timed_out_o`;
  - go to LAUNCH.

**LAUNCH** (exactly one cycle)
- `ctrl_start_o = 1` and `ap_ready = 1`.
- Go to RUN.

**RUN**
- `sticky[i]` sets on `chan_done_i[i]`. Done inputs are ignored in IDLE and LAUNCH.
- Channel i counts as complete when `sticky[i] | ~mask[i]`.
- When all channels are complete, go to DONE. An all-zero mask therefore gives exactly one RUN cycle.
- A done pulse arriving in the same cycle it completes the set is counted.

**DONE**
- `ap_done = 1`.
- If not in chain mode, or if `ap_continue = 1` this cycle: go to IDLE.
- Otherwise: go to HOLD.

**HOLD**
- `ap_done` stays 1.
- On `ap_continue = 1`, go to IDLE.

**Cycle counter**
- `run_cycles_o` increments every cycle in LAUNCH and RUN.
- It saturates at all-ones and holds its value from DONE until the next accept.

**Reset**
- `data_rst_n = 0` at any clock edge forces IDLE, including mid-run.
- `ap_idle = 1`.
- All other outputs go to 0: `ap_ready`, `ap_done`, `ctrl_start_o`, `cfg_bytes_o`, `run_cycles_o`, `timed_out_o`, sticky bits, `start_r`.

## Timing
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- Edge sampled at edge k:
  - k+1: LAUNCH, `ctrl_start_o = 1`, `ap_ready = 1`, `ap_idle = 0`, `cfg_bytes_o` valid.
  - k+2: RUN.
- `cfg_bytes_o` is valid from k+1 and stable until the next accept.
- Final done sampled at edge d: DONE at d+1, `ap_done = 1` for one cycle (hs mode), `ap_idle = 1` at d+2.
- Chain mode: `ap_done` stays high until the cycle after `ap_continue` is sampled high; `ap_idle` rises in that same cycle.
- `ap_done` and `ap_idle` are never both 1.
- Minimum run, edge to `ap_done`: 3 cycles (all-zero mask).

## Configuration
- `KERNEL_RUN_CTRL_TIMEOUT_EN` defined:
  - in RUN, if `timeout_cycles_i != 0` and `run_cycles_o >= timeout_cycles_i`, go to DONE and set `timed_out_o = 1`;
  - `timed_out_o` holds until the next accept;
  - if the last channel completes in the same cycle as the timeout, completion wins and `timed_out_o = 0`.
- Not defined: `timeout_cycles_i` is ignored, `timed_out_o` is tied to 0, and runs wait indefinitely.

## Test plan
- **hs run.** N=3, mask 3'b111, cls {2,10,4}, start; channel done pulses at RUN cycles 5, 9, 20 → `cfg_bytes_o` = {128,640,256} at k+1; one `ctrl_start_o` pulse; `ap_done` for exactly one cycle at cycle d+1; `run_cycles_o` = 22.
- **Chain hold.** `ctrl_chain_i` = 1, all channels done, `ap_continue` asserted 7 cycles after DONE → `ap_done` high for 8 cycles; `ap_idle` rises the following cycle.
- **Mask and stray done.** Mask 3'b010; channels 0 and 2 pulse during LAUNCH, channel 1 pulses at RUN cycle 3 → done follows channel 1 only. All-zero mask → `ap_done` exactly 3 cycles after the edge.
- **Restart rejection.** `ap_start` toggled mid-run → no second `ap_ready` and no change to `cfg_bytes_o`. Held-high `ap_start` after done → no relaunch until it drops and rises again.
- **Reset mid-run.** Reset asserted in RUN → next cycle `ap_idle` = 1, all other outputs 0, and later done pulses are ignored.
- **Watchdog** (macro on). `timeout_cycles_i` = 50, no done inputs → `ap_done` with `timed_out_o` = 1 and `run_cycles_o` = 50. Timeout coinciding with the last done → `timed_out_o` = 0.
